// File: rtl/nn_sm_pkg.sv
// Shared definitions for the sign-magnitude stream decoder: FSM encoding,
// per-sample delta and two's-complement to sign-magnitude helpers.
package nn_sm_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Conversion helpers work at this width; the accumulator (WIN_BITS+2) must fit.
  localparam int SM_W = 32;

  typedef logic signed [1:0] delta_t;

  function automatic delta_t sm_delta(input logic in_bit, input logic sign_bit);
    if (!in_bit) return 2'sd0;
    return sign_bit ? -2'sd1 : 2'sd1;
  endfunction

  // Sign half of the conversion: zero and positive values both report sign 0.
  function automatic logic sm_is_neg(input logic signed [SM_W-1:0] x);
    return x[SM_W-1];
  endfunction

  function automatic logic [SM_W-1:0] sm_abs(input logic signed [SM_W-1:0] x);
    return x[SM_W-1] ? SM_W'(-x) : SM_W'(x);
  endfunction

endpackage

// File: rtl/nn_sm_stream_decoder_if.sv
// Sample-stream input and windowed result output of the stream decoder.
interface nn_sm_stream_decoder_if #(
  parameter int WIN_BITS = 8
);
  logic                EN;
  logic                START;
  logic                IN;
  logic                SIGN_in;
  logic [WIN_BITS:0]   VALUE;
  logic                VALUE_SIGN;
  logic                VALID;
  logic                BUSY;

  modport master (
    output EN, START, IN, SIGN_in,
    input  VALUE, VALUE_SIGN, VALID, BUSY
  );

  modport slave (
    input  EN, START, IN, SIGN_in,
    output VALUE, VALUE_SIGN, VALID, BUSY
  );
endinterface

// File: rtl/nn_sm_updown_counter.sv
// Signed up/down accumulator: adds a -1/0/+1 delta per enabled edge,
// synchronous clear has priority over enable.
module nn_sm_updown_counter
  import nn_sm_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                CLK,
  input  logic                INIT,
  input  logic                clr,
  input  logic                en,
  input  delta_t              delta,
  output logic signed [W-1:0] acc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + W'(delta);
    end
  end

endmodule

// File: rtl/nn_sm_stream_decoder.sv
// Integrates a sign-magnitude stochastic bitstream over 2^WIN_BITS enabled
// samples and reports the windowed sum in sign-magnitude form with a VALID pulse.
module nn_sm_stream_decoder
  import nn_sm_pkg::*;
#(
  parameter int WIN_BITS   = 8,
  parameter int CONTINUOUS = 0
) (
  input  logic                   CLK,
  input  logic                   INIT,
  nn_sm_stream_decoder_if.slave  bus
);

  localparam int ACC_W = WIN_BITS + 2;
  localparam int VAL_W = WIN_BITS + 1;

  logic [0:0]              state;
  logic [WIN_BITS-1:0]     wcnt;
  logic                    in_accum;
  logic                    sample;
  logic                    last_sample;
  logic                    acc_clr;
  delta_t                  delta;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;

  assign in_accum    = (state == ST_ACCUM);
  assign sample      = in_accum && bus.EN;
  assign last_sample = sample && (wcnt == '1);
  assign delta       = sm_delta(bus.IN, bus.SIGN_in);
  // Final sample counts toward its own window, so results use ACC + delta.
  assign acc_sum     = acc + ACC_W'(delta);
  assign acc_clr     = (!in_accum && bus.START) ||
                       (last_sample && (CONTINUOUS != 0));

  nn_sm_updown_counter #(.W(ACC_W)) u_acc (
    .CLK   (CLK),
    .INIT  (INIT),
    .clr   (acc_clr),
    .en    (sample),
    .delta (delta),
    .acc   (acc)
  );

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else if (!in_accum) begin
      wcnt <= '0;
      if (bus.START) state <= ST_ACCUM;
    end else if (sample) begin
      // The window counter wraps to zero on the final sample by itself.
      wcnt <= wcnt + 1'b1;
      if (last_sample && (CONTINUOUS == 0)) state <= ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      bus.VALUE      <= '0;
      bus.VALUE_SIGN <= 1'b0;
      bus.VALID      <= 1'b0;
    end else begin
      bus.VALID <= last_sample;
      if (last_sample) begin
        bus.VALUE      <= VAL_W'(sm_abs(SM_W'(acc_sum)));
        bus.VALUE_SIGN <= sm_is_neg(SM_W'(acc_sum));
      end
    end
  end

  assign bus.BUSY = in_accum;

endmodule

// File: tb/tb_nn_sm_stream_decoder.sv
// Directed bench for the stream decoder at WIN_BITS = 4: one-shot and
// continuous instances share clock and reset.
module tb_nn_sm_stream_decoder;

  localparam int WB = 4;

  logic CLK = 1'b0;
  logic INIT;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   v0_cnt  = 0;

  always #5 CLK = ~CLK;

  nn_sm_stream_decoder_if #(.WIN_BITS(WB)) b0 ();
  nn_sm_stream_decoder_if #(.WIN_BITS(WB)) b1 ();

  nn_sm_stream_decoder #(.WIN_BITS(WB), .CONTINUOUS(0)) dut0 (
    .CLK (CLK), .INIT (INIT), .bus (b0.slave)
  );
  nn_sm_stream_decoder #(.WIN_BITS(WB), .CONTINUOUS(1)) dut1 (
    .CLK (CLK), .INIT (INIT), .bus (b1.slave)
  );

  always @(negedge CLK) if (b0.VALID === 1'b1) v0_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // START cycle carries a negative sample to prove START does not sample IN.
  task automatic run_win(input string tag, input logic [15:0] in_v, input logic [15:0] sign_v,
                         input logic start_last, input int exp_mag, input logic exp_sign);
    int c0;
    b0.START = 1'b1; b0.EN = 1'b1; b0.IN = 1'b1; b0.SIGN_in = 1'b1;
    tick;
    b0.START = 1'b0;
    check({tag, " busy_start"}, 32'(b0.BUSY), 1);
    c0 = v0_cnt;
    for (int i = 0; i < 16; i++) begin
      b0.EN = 1'b1; b0.IN = in_v[i]; b0.SIGN_in = sign_v[i];
      b0.START = (i == 15) && start_last;
      tick;
    end
    b0.EN = 1'b0; b0.IN = 1'b0; b0.SIGN_in = 1'b0; b0.START = 1'b0;
    check({tag, " early_valid"}, 32'(v0_cnt - c0), 0);
    check({tag, " valid"}, 32'(b0.VALID), 1);
    check({tag, " value"}, 32'(b0.VALUE), 32'(exp_mag));
    check({tag, " sign"}, 32'(b0.VALUE_SIGN), 32'(exp_sign));
    check({tag, " busy_end"}, 32'(b0.BUSY), 0);
    tick;
    check({tag, " valid_drop"}, 32'(b0.VALID), 0);
    check({tag, " value_hold"}, 32'(b0.VALUE), 32'(exp_mag));
    check({tag, " idle_stays"}, 32'(b0.BUSY), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int busy_low;
    int n_pulse;
    int pulse_at [3];

    INIT = 1'b1;
    b0.EN = 1'b0; b0.START = 1'b0; b0.IN = 1'b0; b0.SIGN_in = 1'b0;
    b1.EN = 1'b0; b1.START = 1'b0; b1.IN = 1'b0; b1.SIGN_in = 1'b0;
    tick; tick;
    INIT = 1'b0;
    check("reset value", 32'(b0.VALUE), 0);
    check("reset sign", 32'(b0.VALUE_SIGN), 0);
    check("reset valid", 32'(b0.VALID), 0);
    check("reset busy0", 32'(b0.BUSY), 0);
    check("reset busy1", 32'(b1.BUSY), 0);

    run_win("all_pos", 16'hFFFF, 16'h0000, 1'b0, 16, 1'b0);

    // Reset in the middle of a window: partial window discarded, async clear.
    b0.START = 1'b1; tick; b0.START = 1'b0;
    c0 = v0_cnt;
    for (int i = 0; i < 7; i++) begin
      b0.EN = 1'b1; b0.IN = 1'b1; b0.SIGN_in = 1'b0;
      tick;
    end
    #2 INIT = 1'b1;
    #1;
    check("midrst value", 32'(b0.VALUE), 0);
    check("midrst sign", 32'(b0.VALUE_SIGN), 0);
    check("midrst busy", 32'(b0.BUSY), 0);
    check("midrst valid", 32'(b0.VALID), 0);
    INIT = 1'b0;
    for (int i = 0; i < 16; i++) tick;
    check("midrst no_valid", 32'(v0_cnt - c0), 0);
    check("midrst still_idle", 32'(b0.BUSY), 0);
    b0.EN = 1'b0; b0.IN = 1'b0;

    run_win("mixed", 16'h3FFF, 16'hC3FF, 1'b0, 6, 1'b1);
    run_win("all_neg", 16'hFFFF, 16'hFFFF, 1'b0, 16, 1'b1);
    run_win("balanced", 16'hFFFF, 16'hFF00, 1'b0, 0, 1'b0);
    run_win("sign_no_in", 16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);

    // EN gaps at cycles 3,4 and 17-19 (17 would have been the final edge).
    b0.START = 1'b1; tick; b0.START = 1'b0;
    c0 = v0_cnt;
    for (int c = 0; c < 21; c++) begin
      if (c == 3 || c == 4 || (c >= 17 && c <= 19)) begin
        b0.EN = 1'b0; b0.IN = 1'b1; b0.SIGN_in = 1'b1; b0.START = 1'b1;
      end else begin
        b0.EN = 1'b1; b0.IN = 1'b1; b0.SIGN_in = 1'b0; b0.START = 1'b0;
      end
      tick;
      if (c == 19) begin
        check("engap no_early", 32'(v0_cnt - c0), 0);
        check("engap valid_c20", 32'(b0.VALID), 0);
        check("engap busy_c20", 32'(b0.BUSY), 1);
      end
    end
    b0.EN = 1'b0; b0.IN = 1'b0; b0.SIGN_in = 1'b0; b0.START = 1'b0;
    check("engap valid", 32'(b0.VALID), 1);
    check("engap value", 32'(b0.VALUE), 16);
    check("engap sign", 32'(b0.VALUE_SIGN), 0);
    check("engap busy_end", 32'(b0.BUSY), 0);
    tick;

    // Continuous mode: 48 positive samples, pulses expected at 16, 32, 48.
    busy_low = 0;
    n_pulse  = 0;
    pulse_at = '{default: 0};
    b1.START = 1'b1; tick; b1.START = 1'b0;
    b1.EN = 1'b1; b1.IN = 1'b1; b1.SIGN_in = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick;
      if (b1.BUSY !== 1'b1) busy_low++;
      if (b1.VALID === 1'b1) begin
        if (n_pulse < 3) pulse_at[n_pulse] = k;
        n_pulse++;
        check("cont value", 32'(b1.VALUE), 16);
        check("cont sign", 32'(b1.VALUE_SIGN), 0);
      end
    end
    b1.EN = 1'b0; b1.IN = 1'b0;
    check("cont pulses", 32'(n_pulse), 3);
    check("cont pulse1", 32'(pulse_at[0]), 16);
    check("cont pulse2", 32'(pulse_at[1]), 32);
    check("cont pulse3", 32'(pulse_at[2]), 48);
    check("cont busy_low", 32'(busy_low), 0);
    tick;
    check("cont valid_drop", 32'(b1.VALID), 0);
    check("cont busy_hold", 32'(b1.BUSY), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
